guarded_updown_counter: RTL
===========================

// Module: guarded_updown_counter
// PURPOSE
//  Parametrised up/down/loadable counter with self-checking guard words: registered even-bit and
//  odd-bit popcounts are stored alongside the count and re-checked every cycle. A mismatch means the
//  count register was upset (SEU, glitch). The block halts, flags it, counts it and waits for recovery.
//  Successor of the fixed 8-bit free-running guarded counter; used in radiation-exposed control paths.
// PARAMETERS
//  WIDTH      8           counter width, >= 2
//  MAX_VAL    2**WIDTH-1  terminal value; counter is modulo MAX_VAL+1
//  ERR_CNT_W  8           width of the saturating error counter
//  GUARD_BITS (localparam) $clog2((WIDTH+1)/2+1); wide enough for a full even/odd popcount
// PORTS
//  clk       in   1           clock
//  rstn      in   1           reset, synchronous, active-low
//  en        in   1           count step enable
//  up        in   1           1 = increment, 0 = decrement
//  load      in   1           load load_val; priority over en
//  load_val  in   WIDTH       load value; values > MAX_VAL are clamped to MAX_VAL
//  clr_err   in   1           leave FAULT, clear err (err_cnt is kept)
//  count     out  WIDTH       counter value
//  even_pop  out  GUARD_BITS  stored popcount of count[0],[2],[4],...
//  odd_pop   out  GUARD_BITS  stored popcount of count[1],[3],[5],...
//  tc        out  1           1-cycle pulse on wrap (MAX_VAL->0 up, 0->MAX_VAL down)
//  err       out  1           sticky guard-mismatch flag
//  err_cnt   out  ERR_CNT_W   saturating count of mismatch events
//  state     out  2           FSM state (package encoding)
// BEHAVIOUR
//  Reset (rstn=0 at posedge): count=0, even_pop=0, odd_pop=0, tc=0, err=0, err_cnt=0, state=IDLE.
//  FSM: IDLE -> RUN on first cycle with en|load. RUN -> FAULT on mismatch. FAULT -> RECOVER on clr_err.
//   RECOVER -> RUN after exactly 1 cycle.
//  Guard update: whenever count is written, even_pop/odd_pop are written in the same edge.
//   They are computed from the NEXT count value, so a fault-free design never mismatches.
//  Check (RUN only): mismatch = (popcount_even(count)!=even_pop) | (popcount_odd(count)!=odd_pop).
//   Combinational on registered values.
//  On mismatch, at the next edge: err=1, err_cnt+=1 (saturates at all-ones), state=FAULT,
//   count does NOT update that edge.
//  FAULT: count/guards hold; en and load are ignored; tc=0; no further err_cnt increments.
//  RECOVER: guards are reloaded from popcount of the current count; count holds; err cleared.
//   The count value is kept as-is; the recovery policy belongs to software.
//  Count step (RUN): load -> count=min(load_val,MAX_VAL), tc=0.
//   Else en&up -> count==MAX_VAL ? 0 : count+1.
//   Else en&!up -> count==0 ? MAX_VAL : count-1.
//   tc=1 for exactly the cycle after a wrap step.
//  Latency: count, guards and tc are valid 1 cycle after the en/load sample.
//   err is high 1 cycle after a corrupted count becomes visible.
//  Simultaneous: mismatch in the same cycle as en/load -> fault wins, no step.
//   clr_err while in RUN or IDLE -> no effect. clr_err held in FAULT -> one RECOVER, then RUN.
//  Reset mid-FAULT or mid-RECOVER returns all outputs to their reset values.
// CONFIGURATION
//  GUARDED_CNT_FAULT_INJ_EN defined: extra input inj_flip [WIDTH-1:0].
//   In RUN, the count register is XORed with inj_flip at the edge, with guards NOT updated.
//   This is for self-test and verification.
//  Not defined: port absent; count is written only by step/load logic.
// STRUCTURE
//  Package guarded_cnt_pkg:
//   - state typedef enum {IDLE=2'd0, RUN=2'd1, FAULT=2'd2, RECOVER=2'd3}
//   - functions pop_even(), pop_odd()
//  Sub-module guard_popcount: combinational, WIDTH in, even/odd GUARD_BITS out.
//   One instance checks the current count, one computes the next-count guards.
// TESTING
//  1. Reset, en=1 up=1, 256 cycles (WIDTH=8) -> count 0..255..0; tc once at 255->0; err stays 0.
//  2. MAX_VAL=9, up=0 from 0 -> count 9,8,...; tc on 0->9; load_val=200 -> count=9.
//  3. FAULT_INJ_EN, count=0x05, inj_flip=0x02 -> count=0x07, err=1 next cycle, err_cnt=1,
//     state=FAULT, count holds while en=1.
//  4. From test 3: clr_err pulse -> RECOVER 1 cycle, guards even=2 odd=1, RUN, counting resumes from 0x07.
//  5. Inject 300 faults with ERR_CNT_W=8, clearing each -> err_cnt saturates at 255.
//  6. rstn=0 during FAULT -> all outputs at reset values next edge; state=IDLE.
//     load and en in the same cycle -> load wins.

Source files
------------

// File: rtl/guarded_updown_counter_pkg.sv
// Shared types and helpers for the guarded up/down counter: FSM state encoding and
// even/odd-bit popcount functions used for the guard words.
package guarded_cnt_pkg;

  // Widest count the popcount helpers accept; callers zero-extend into this.
  localparam int unsigned POP_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  function automatic int unsigned pop_even(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i += 2) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic int unsigned pop_odd(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 1; i < POP_MAX_W; i += 2) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/guard_popcount.sv
// Combinational even-bit / odd-bit popcount of a WIDTH-bit value, sized to the guard words.
module guard_popcount
  import guarded_cnt_pkg::*;
#(
  parameter  int unsigned WIDTH      = 8,
  localparam int unsigned GUARD_BITS = $clog2((WIDTH + 1) / 2 + 1)
) (
  input  logic [WIDTH-1:0]      v_i,
  output logic [GUARD_BITS-1:0] even_o,
  output logic [GUARD_BITS-1:0] odd_o
);

  logic [POP_MAX_W-1:0] ext;

  always_comb begin
    ext             = '0;
    ext[WIDTH-1:0]  = v_i;
  end

  assign even_o = GUARD_BITS'(pop_even(ext));
  assign odd_o  = GUARD_BITS'(pop_odd(ext));

endmodule

// File: rtl/guarded_updown_counter.sv
// Up/down/loadable modulo counter with registered even/odd popcount guard words checked every
// cycle in RUN. Optional GUARDED_CNT_FAULT_INJ_EN adds inj_flip to corrupt the count for self-test.
module guarded_updown_counter
  import guarded_cnt_pkg::*;
#(
  parameter  int unsigned      WIDTH      = 8,
  parameter  logic [WIDTH-1:0] MAX_VAL    = '1,
  parameter  int unsigned      ERR_CNT_W  = 8,
  localparam int unsigned      GUARD_BITS = $clog2((WIDTH + 1) / 2 + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clr_err,
`ifdef GUARDED_CNT_FAULT_INJ_EN
  input  logic [WIDTH-1:0]      inj_flip,
`endif
  output logic [WIDTH-1:0]      count,
  output logic [GUARD_BITS-1:0] even_pop,
  output logic [GUARD_BITS-1:0] odd_pop,
  output logic                  tc,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [1:0]            state
);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [GUARD_BITS-1:0] even_q, even_d, odd_q, odd_d;
  logic                  tc_q, tc_d, err_q, err_d;
  logic [ERR_CNT_W-1:0]  errcnt_q, errcnt_d;

  logic [WIDTH-1:0]      step_val, load_clamped, flip;
  logic                  step_wrap, mismatch;
  logic [GUARD_BITS-1:0] chk_even, chk_odd, nxt_even, nxt_odd;

`ifdef GUARDED_CNT_FAULT_INJ_EN
  assign flip = inj_flip;
`else
  assign flip = '0;
`endif

  guard_popcount #(.WIDTH(WIDTH)) u_chk (
    .v_i    (count_q),
    .even_o (chk_even),
    .odd_o  (chk_odd)
  );

  guard_popcount #(.WIDTH(WIDTH)) u_nxt (
    .v_i    (step_val),
    .even_o (nxt_even),
    .odd_o  (nxt_odd)
  );

  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  assign mismatch     = (state_q == RUN) && ((chk_even != even_q) || (chk_odd != odd_q));

  always_comb begin
    step_val  = count_q;
    step_wrap = 1'b0;
    if (load) begin
      step_val = load_clamped;
    end else if (en) begin
      if (up) begin
        if (count_q == MAX_VAL) begin
          step_val  = '0;
          step_wrap = 1'b1;
        end else begin
          step_val = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          step_val  = MAX_VAL;
          step_wrap = 1'b1;
        end else begin
          step_val = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    even_d   = even_q;
    odd_d    = odd_q;
    tc_d     = 1'b0;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    unique case (state_q)
      // The sample that wakes the counter also takes effect, keeping the 1-cycle latency.
      IDLE: begin
        if (en || load) begin
          state_d = RUN;
          count_d = step_val;
          even_d  = nxt_even;
          odd_d   = nxt_odd;
          tc_d    = step_wrap;
        end
      end
      RUN: begin
        if (mismatch) begin
          state_d = FAULT;
          err_d   = 1'b1;
          if (errcnt_q != '1) errcnt_d = errcnt_q + ERR_CNT_W'(1);
        end else begin
          count_d = step_val ^ flip;
          even_d  = nxt_even;
          odd_d   = nxt_odd;
          tc_d    = step_wrap;
        end
      end
      FAULT: begin
        if (clr_err) state_d = RECOVER;
      end
      RECOVER: begin
        even_d  = chk_even;
        odd_d   = chk_odd;
        err_d   = 1'b0;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      even_q   <= '0;
      odd_q    <= '0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      even_q   <= even_d;
      odd_q    <= odd_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign count    = count_q;
  assign even_pop = even_q;
  assign odd_pop  = odd_q;
  assign tc       = tc_q;
  assign err      = err_q;
  assign err_cnt  = errcnt_q;
  assign state    = state_q;

endmodule
